// File: rtl/calc_pkg.sv
// Shared constants, state type and helpers for the calculator command issuer.
// Holds the default data width, the function codes and the legality check.
package calc_pkg;

  localparam int CALC_DW = 32;

  localparam logic [3:0] FN_NONE = 4'b0000;
  localparam logic [3:0] FN_LEN2 = 4'b1000;
  localparam logic [3:0] FN_LEN3 = 4'b1010;
  localparam logic [3:0] FN_LEN4 = 4'b1011;
  localparam logic [3:0] FN_IP2  = 4'b1100;
  localparam logic [3:0] FN_IP3  = 4'b1110;
  localparam logic [3:0] FN_IP4  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  function automatic logic fn_legal(input logic [3:0] f);
    logic ok;
    ok = 1'b0;
    case (f)
      FN_LEN2, FN_LEN3, FN_LEN4,
      FN_IP2, FN_IP3, FN_IP4: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/calc_wait_ctr.sv
// Down-counter timing the calculator latency window.
// Ports: clk, rst, load (strobe), value (load value), zero (count is 0).
module calc_wait_ctr
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] value,
  output logic       zero
);

  logic [7:0] cnt_d;
  logic [7:0] cnt_q;

  // Free-runs down to 0 and parks there until the next load.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 8'd0);

endmodule

// File: rtl/calc_cmd_issuer.sv
// Issues one command to a fixed-latency vector calculator, waits LAT cycles,
// captures the result and hands it out on a valid/ready response port.
// Ports: req_* request in, func/calc_v1/calc_v2 out to the calculator,
// calc_len/calc_ip/calc_ovf from the calculator, rsp_* response out.
// Option: CALC_CMD_OVF_STICKY_EN accumulates overflow over ISSUE and WAIT.
module calc_cmd_issuer
  import calc_pkg::*;
#(
  parameter int LAT = 40,
  parameter int DW  = CALC_DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_func,
  input  logic [4*DW-1:0] req_v1,
  input  logic [4*DW-1:0] req_v2,
  output logic [3:0]      func,
  output logic [4*DW-1:0] calc_v1,
  output logic [4*DW-1:0] calc_v2,
  input  logic [DW-1:0]   calc_len,
  input  logic [DW-1:0]   calc_ip,
  input  logic [7:0]      calc_ovf,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_data,
  output logic [3:0]      rsp_ovf,
  output logic            rsp_err
);

  localparam int         VW      = 4 * DW;
  localparam logic [7:0] WAIT_LD = 8'(LAT - 1);

  state_e state_d, state_q;

  logic [3:0]    func_d, func_q;
  logic [VW-1:0] v1_d, v1_q;
  logic [VW-1:0] v2_d, v2_q;
  logic [DW-1:0] data_d, data_q;
  logic [3:0]    ovf_d, ovf_q;
  logic          err_d, err_q;

  logic          ctr_load;
  logic          ctr_zero;
  logic [3:0]    ovf_sel;

  // B1=0 drops z and w, B0=0 drops w.
  function automatic logic [VW-1:0] mask_vec(
    input logic [VW-1:0] v,
    input logic [3:0]    f
  );
    logic [VW-1:0] m;
    m = v;
    if (!f[1]) m[VW-1:2*DW] = '0;
    if (!f[0]) m[VW-1:3*DW] = '0;
    return m;
  endfunction

  assign ovf_sel = func_q[2] ? calc_ovf[7:4] : calc_ovf[3:0];

  calc_wait_ctr u_ctr (
    .clk   (clk),
    .rst   (rst),
    .load  (ctr_load),
    .value (WAIT_LD),
    .zero  (ctr_zero)
  );

  always_comb begin
    state_d  = state_q;
    func_d   = func_q;
    v1_d     = v1_q;
    v2_d     = v2_q;
    data_d   = data_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    ctr_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          data_d = '0;
          ovf_d  = '0;
          if (fn_legal(req_func)) begin
            func_d  = req_func;
            v1_d    = mask_vec(req_v1, req_func);
            v2_d    = mask_vec(req_v2, req_func);
            err_d   = 1'b0;
            state_d = ST_ISSUE;
          end else begin
            // Never reaches the calculator; func stays 0.
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        ctr_load = 1'b1;
        state_d  = ST_WAIT;
`ifdef CALC_CMD_OVF_STICKY_EN
        ovf_d = ovf_q | ovf_sel;
`endif
      end
      ST_WAIT: begin
`ifdef CALC_CMD_OVF_STICKY_EN
        ovf_d = ovf_q | ovf_sel;
`endif
        if (ctr_zero) begin
          data_d  = func_q[2] ? calc_ip : calc_len;
`ifndef CALC_CMD_OVF_STICKY_EN
          ovf_d   = ovf_sel;
`endif
          func_d  = FN_NONE;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          v1_d    = '0;
          v2_d    = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      func_q  <= FN_NONE;
      v1_q    <= '0;
      v2_q    <= '0;
      data_q  <= '0;
      ovf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign func      = func_q;
  assign calc_v1   = v1_q;
  assign calc_v2   = v2_q;
  assign rsp_data  = data_q;
  assign rsp_ovf   = ovf_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_calc_cmd_issuer.sv
// Randomized self-checking bench for calc_cmd_issuer against a
// transaction-level model of issue, latency window and response.
module tb_calc_cmd_issuer;

  localparam int LAT = 8;
  localparam int DW  = 32;
  localparam int VW  = 4 * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_func;
  logic [VW-1:0] req_v1;
  logic [VW-1:0] req_v2;
  logic [3:0]    func;
  logic [VW-1:0] calc_v1;
  logic [VW-1:0] calc_v2;
  logic [DW-1:0] calc_len;
  logic [DW-1:0] calc_ip;
  logic [7:0]    calc_ovf;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [3:0]    rsp_ovf;
  logic          rsp_err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] lseq [0:LAT];
  logic [DW-1:0] iseq [0:LAT];
  logic [7:0]    oseq [0:LAT];

  logic [3:0] legal_fn [6] = '{4'b1000, 4'b1010, 4'b1011,
                               4'b1100, 4'b1110, 4'b1111};

  calc_cmd_issuer #(.LAT(LAT), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_func  (req_func),
    .req_v1    (req_v1),
    .req_v2    (req_v2),
    .func      (func),
    .calc_v1   (calc_v1),
    .calc_v2   (calc_v2),
    .calc_len  (calc_len),
    .calc_ip   (calc_ip),
    .calc_ovf  (calc_ovf),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_ovf   (rsp_ovf),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [VW-1:0] got,
                     input logic [VW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [3:0] f);
    bit ok;
    ok = 0;
    foreach (legal_fn[i]) if (legal_fn[i] == f) ok = 1;
    return ok;
  endfunction

  // Components kept: x,y always; z with 3rd dim; w with 3rd and 4th dim.
  function automatic logic [VW-1:0] model_vec(input logic [VW-1:0] v,
                                              input logic [3:0] f);
    logic [VW-1:0] r;
    r = '0;
    r[2*DW-1:0] = v[2*DW-1:0];
    if (f[1]) r[3*DW-1:2*DW] = v[3*DW-1:2*DW];
    if (f[1] && f[0]) r[4*DW-1:3*DW] = v[4*DW-1:3*DW];
    return r;
  endfunction

  function automatic logic [3:0] pick(input logic [7:0] o,
                                      input logic [3:0] f);
    return f[2] ? o[7:4] : o[3:0];
  endfunction

  task automatic run_txn(input logic [3:0] f, input logic [VW-1:0] a,
                         input logic [VW-1:0] b, input int hold,
                         input bit busy_req, input int omode,
                         input bit ip_force);
    logic [VW-1:0] ea, eb;
    logic [DW-1:0] ed;
    logic [3:0]    eo;
    bit            ee;
    for (int k = 0; k <= LAT; k++) begin
      lseq[k] = $urandom;
      iseq[k] = $urandom;
      oseq[k] = (omode == 1) ? ((k == LAT / 2) ? 8'h20 : 8'h00)
                             : 8'($urandom);
    end
    if (ip_force) iseq[LAT] = 32'h0005_0000;
    req_func  = f;
    req_v1    = a;
    req_v2    = b;
    req_valid = 1'b1;
    @(negedge clk);
    chk("req_ready_idle", VW'(req_ready), VW'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    ee = !is_legal(f);
    ed = '0;
    eo = '0;
    if (!ee) begin
      ea = model_vec(a, f);
      eb = model_vec(b, f);
      for (int k = 0; k <= LAT; k++) begin
        calc_len = lseq[k];
        calc_ip  = iseq[k];
        calc_ovf = oseq[k];
        @(negedge clk);
        chk("func_held", VW'(func), VW'(f));
        chk("v1_held", calc_v1, ea);
        chk("v2_held", calc_v2, eb);
        chk("no_rsp_early", VW'(rsp_valid), VW'(0));
        chk("busy_ready", VW'(req_ready), VW'(0));
        @(posedge clk); #1;
      end
      ed = f[2] ? iseq[LAT] : lseq[LAT];
`ifdef CALC_CMD_OVF_STICKY_EN
      for (int k = 0; k <= LAT; k++) eo |= pick(oseq[k], f);
`else
      eo = pick(oseq[LAT], f);
`endif
    end
    for (int h = 0; h <= hold; h++) begin
      if (busy_req) begin
        req_valid = 1'b1;
        req_func  = legal_fn[$urandom_range(5)];
        req_v1    = {4{32'($urandom)}};
        req_v2    = {4{32'($urandom)}};
      end
      rsp_ready = (h == hold);
      @(negedge clk);
      chk("rsp_valid", VW'(rsp_valid), VW'(1));
      chk("rsp_data", VW'(rsp_data), VW'(ed));
      chk("rsp_ovf", VW'(rsp_ovf), VW'(eo));
      chk("rsp_err", VW'(rsp_err), VW'(ee));
      chk("rsp_func0", VW'(func), VW'(0));
      chk("rsp_ready_out", VW'(req_ready), VW'(0));
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0;
    chk("post_valid", VW'(rsp_valid), VW'(0));
    chk("post_func", VW'(func), VW'(0));
    chk("post_v1", calc_v1, '0);
    chk("post_v2", calc_v2, '0);
    chk("post_ready", VW'(req_ready), VW'(1));
  endtask

  initial begin
    logic [VW-1:0] va, vb;
    logic [3:0]    f;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_func  = '0;
    req_v1    = '0;
    req_v2    = '0;
    calc_len  = '0;
    calc_ip   = '0;
    calc_ovf  = '0;
    rsp_ready = 1'b0;
    #1;
    chk("rst_func", VW'(func), VW'(0));
    chk("rst_v1", calc_v1, '0);
    chk("rst_v2", calc_v2, '0);
    chk("rst_valid", VW'(rsp_valid), VW'(0));
    chk("rst_data", VW'(rsp_data), VW'(0));
    chk("rst_ovf", VW'(rsp_ovf), VW'(0));
    chk("rst_err", VW'(rsp_err), VW'(0));
    chk("rst_ready", VW'(req_ready), VW'(1));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    va = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0002_0000, 32'h0001_0000};
    vb = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    run_txn(4'b1000, va, vb, 0, 0, 0, 0);
    run_txn(4'b1111, va, vb, 1, 0, 0, 1);
    run_txn(4'b1001, va, vb, 0, 0, 0, 0);
    run_txn(4'b1010, vb, va, 10, 1, 0, 0);
    run_txn(4'b1011, va, vb, 0, 0, 0, 0);
    run_txn(4'b1100, va, vb, 2, 0, 1, 0);
    run_txn(4'b0000, va, vb, 0, 0, 0, 0);

    // Reset while the wait counter reads 5, then a clean request.
    req_func  = 4'b1011;
    req_v1    = va;
    req_v2    = vb;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_func", VW'(func), VW'(4'b1011));
    rst = 1'b1;
    #1;
    chk("arst_func", VW'(func), VW'(0));
    chk("arst_v1", calc_v1, '0);
    chk("arst_v2", calc_v2, '0);
    chk("arst_data", VW'(rsp_data), VW'(0));
    chk("arst_ovf", VW'(rsp_ovf), VW'(0));
    chk("arst_err", VW'(rsp_err), VW'(0));
    repeat (3) begin
      @(negedge clk);
      chk("arst_novalid", VW'(rsp_valid), VW'(0));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      chk("abort_novalid", VW'(rsp_valid), VW'(0));
    end
    @(posedge clk); #1;
    run_txn(4'b1110, vb, va, 0, 0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(3) != 0) f = legal_fn[$urandom_range(5)];
      else f = 4'($urandom);
      va = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
      vb = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
      run_txn(f, va, vb, $urandom_range(3), 1'($urandom), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_cmd_issuer.md
CALC_CMD_ISSUER -- requirements
Module: calc_cmd_issuer

Interface
REQ-001 SHALL have parameter LAT, default 40, meaning the number of cycles from command issue to result sample (legal range 2..255).
REQ-002 SHALL have parameter DW, default 32, meaning the width of each vector component and of each result.
REQ-003 SHALL have port clk  in  1  meaning the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst  in  1  meaning an asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  in  1  meaning a request is present.
REQ-006 SHALL have port req_ready  out  1  meaning the block accepts a request.
REQ-007 SHALL have port req_func  in  4  meaning the function code {B3 run, B2 inner-product, B1 3rd dim, B0 4th dim}.
REQ-008 SHALL have port req_v1  in  4*DW  meaning vector 1, packed {w,z,y,x} with x in the LSBs.
REQ-009 SHALL have port req_v2  in  4*DW  meaning vector 2, packed {w,z,y,x} with x in the LSBs.
REQ-010 SHALL have port func  out  4  meaning the function code driven to the calculator.
REQ-011 SHALL have port calc_v1  out  4*DW  meaning the masked vector 1 driven to the calculator.
REQ-012 SHALL have port calc_v2  out  4*DW  meaning the masked vector 2 driven to the calculator.
REQ-013 SHALL have port calc_len  in  DW  meaning the calculator length result.
REQ-014 SHALL have port calc_ip  in  DW  meaning the calculator inner-product result.
REQ-015 SHALL have port calc_ovf  in  8  meaning calculator overflow flags: [3:0] length multipliers, [7:4] inner-product multipliers.
REQ-016 SHALL have port rsp_valid  out  1  meaning a response is present.
REQ-017 SHALL have port rsp_ready  in  1  meaning the consumer accepts the response.
REQ-018 SHALL have port rsp_data  out  DW  meaning the result.
REQ-019 SHALL have port rsp_ovf  out  4  meaning the overflow flags of the selected function.
REQ-020 SHALL have port rsp_err  out  1  meaning the request carried an illegal function code.

Function
REQ-021 SHALL implement states IDLE, ISSUE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-022 SHALL treat as legal only function codes 1000, 1010, 1011, 1100, 1110 and 1111; all other codes are illegal.
REQ-023 SHALL, on req_valid&&req_ready with an illegal code, go to RESP with rsp_err=1, rsp_data=0, rsp_ovf=0, and SHALL not drive func.
REQ-024 SHALL, on acceptance of a legal code, register func and the operands and go to ISSUE; B1=0 SHALL zero the z and w components of both vectors, and B0=0 SHALL zero the w component.
REQ-025 SHALL hold func, calc_v1 and calc_v2 stable from ISSUE through the end of WAIT; ISSUE SHALL last one cycle.
REQ-026 SHALL load the WAIT counter with LAT-1 on entry and decrement it each cycle; on the cycle the counter is 0 it SHALL capture rsp_data (calc_ip if B2=1, else calc_len) and rsp_ovf (calc_ovf[7:4] if B2=1, else [3:0]), then go to RESP.
REQ-027 SHALL hold rsp_valid=1 and the response stable in RESP until rsp_ready=1; on the handshake cycle it SHALL return to IDLE and drive func=0000 with both vectors at 0.
REQ-028 SHALL ignore req_valid outside IDLE; a request arriving during RESP is accepted only after the return to IDLE.
REQ-029 SHALL keep func=0000 whenever the state is IDLE or RESP.

Reset
REQ-030 SHALL, on rst, asynchronously force IDLE with func=0, calc_v1=0, calc_v2=0, rsp_valid=0, rsp_data=0, rsp_ovf=0, rsp_err=0, counter=0.
REQ-031 SHALL, on rst asserted mid-WAIT or mid-RESP, abort the command without producing a response; the first post-reset request SHALL be handled normally.

Configuration
REQ-032 SHALL, when CALC_CMD_OVF_STICKY_EN is defined, OR-accumulate the selected overflow bits on every cycle of ISSUE and WAIT into rsp_ovf, clearing them on acceptance.
REQ-033 SHALL, when CALC_CMD_OVF_STICKY_EN is undefined, sample rsp_ovf only on the capture cycle.

Structure
REQ-034 SHALL take the function-code constants, the state typedef and the default DW from shared package calc_pkg.
REQ-035 SHALL implement the WAIT counter as sub-module calc_wait_ctr, with ports load, value and zero.

Verification
REQ-036 SHALL cover: req_func=1000, v1 x=0x00010000, y=0x00020000, z=w=0xFFFFFFFF -> calc_v1 z,w=0 during WAIT; rsp_data = calc_len sampled exactly LAT+1 cycles after acceptance.
REQ-037 SHALL cover: req_func=1111, model calc_ip=0x00050000 -> rsp_data=0x00050000, rsp_err=0, func held at 1111 for LAT+1 cycles.
REQ-038 SHALL cover: req_func=1001 -> rsp_valid on the next cycle, rsp_err=1, rsp_data=0, func stays 0000.
REQ-039 SHALL cover: rsp_ready held at 0 for 10 cycles in RESP while req_valid=1 -> response stable, req_ready=0, new request accepted only the cycle after the handshake.
REQ-040 SHALL cover: calc_ovf[5] pulsed for one mid-WAIT cycle on 1100 -> rsp_ovf=0010 with CALC_CMD_OVF_STICKY_EN defined, 0000 without it.
REQ-041 SHALL cover: rst asserted at WAIT counter=5 -> all outputs 0 immediately, no rsp_valid, and the next request completes correctly.
